// File: rtl/md_coil_freq_axil_if.sv
// md_coil_freq_axil_if: AXI4-Lite bus bundle between a master and the coil frequency block
interface md_coil_freq_axil_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                      awprot;
    logic                            awvalid;
    logic                            awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                            wvalid;
    logic                            wready;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                      arprot;
    logic                            arvalid;
    logic                            arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      rresp;
    logic                            rvalid;
    logic                            rready;
    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/md_coil_freq_axil.sv
// md_coil_freq_axil: AXI4-Lite coil oscillator frequency counter with baseline deviation detect
module md_coil_freq_axil #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic               s00_axi_aclk,
    input  logic               s00_axi_areset,
    md_coil_freq_axil_if.slave s00_axi,
    input  logic               coil_in,
    output logic               irq
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    logic          alive, aw_full, w_full, bvalid, rvalid, done, detect;
    logic          aw_hs, w_hs, ar_hs, commit, w1c, edge_det, term, en, unused;
    logic [AW-1:0] aw_addr, wa;
    logic [DW/8-1:0] w_strb, ws;
    logic [DW-1:0] w_data, wd, rdata, rd_mux;
    logic [DW-1:0] ctrl, gate, base, thresh, count;
    logic [DW-1:0] win_gate, win_base, win_thresh, gate_cnt, edge_cnt, edge_sum, last_cnt, dev;
    logic [2:0]    sync;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [DW/8-1:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < DW/8; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    assign s00_axi.awready = alive & ~aw_full & ~bvalid;
    assign s00_axi.wready  = alive & ~w_full & ~bvalid;
    assign s00_axi.arready = alive & ~rvalid;
    assign s00_axi.bvalid  = bvalid;
    assign s00_axi.bresp   = 2'b00;
    assign s00_axi.rvalid  = rvalid;
    assign s00_axi.rdata   = rdata;
    assign s00_axi.rresp   = 2'b00;
    assign en              = ctrl[0];
    assign unused          = ^{s00_axi.awprot, s00_axi.arprot, wa[1:0], s00_axi.araddr[1:0]};

    // Handshakes, write merge from holding slots, window terminal detection and read mux
    always_comb begin
        aw_hs    = s00_axi.awvalid & s00_axi.awready;
        w_hs     = s00_axi.wvalid & s00_axi.wready;
        ar_hs    = s00_axi.arvalid & s00_axi.arready;
        commit   = (aw_full | aw_hs) & (w_full | w_hs) & ~bvalid;
        wa       = aw_full ? aw_addr : s00_axi.awaddr;
        wd       = w_full ? w_data : s00_axi.wdata;
        ws       = w_full ? w_strb : s00_axi.wstrb;
        w1c      = commit & (wa[4:2] == 3'd5) & ws[0] & wd[0];
        edge_det = sync[1] & ~sync[2];
        edge_sum = (edge_det && edge_cnt != '1) ? edge_cnt + 1'b1 : edge_cnt;
        last_cnt = (win_gate == '0) ? '0 : win_gate - 1'b1;
        term     = en & (gate_cnt == last_cnt);
        dev      = (edge_sum > win_base) ? edge_sum - win_base : win_base - edge_sum;
        rd_mux   = '0;
        case (s00_axi.araddr[4:2])
            3'd0: rd_mux = ctrl;
            3'd1: rd_mux = gate;
            3'd2: rd_mux = base;
            3'd3: rd_mux = thresh;
            3'd4: rd_mux = count;
            3'd5: rd_mux = {{(DW-2){1'b0}}, detect, done};
            default: rd_mux = '0;
        endcase
    end

    // Write address/data holding slots and the write response
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            alive   <= 1'b0;
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
            end else begin
                if (aw_hs) begin
                    aw_full <= 1'b1;
                    aw_addr <= s00_axi.awaddr;
                end
                if (w_hs) begin
                    w_full <= 1'b1;
                    w_data <= s00_axi.wdata;
                    w_strb <= s00_axi.wstrb;
                end
                if (bvalid && s00_axi.bready) bvalid <= 1'b0;
            end
        end
    end

    // Byte-strobed updates of the RW configuration registers
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            ctrl   <= '0;
            gate   <= '0;
            base   <= '0;
            thresh <= '0;
        end else if (commit) begin
            case (wa[4:2])
                3'd0: ctrl   <= merge(ctrl, wd, ws);
                3'd1: gate   <= merge(gate, wd, ws);
                3'd2: base   <= merge(base, wd, ws);
                3'd3: thresh <= merge(thresh, wd, ws);
                default: ;
            endcase
        end
    end

    // Coil edge counting over the gate window, window result, status and interrupt
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            sync       <= '0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            count      <= '0;
            win_gate   <= '0;
            win_base   <= '0;
            win_thresh <= '0;
            done       <= 1'b0;
            detect     <= 1'b0;
            irq        <= 1'b0;
        end else begin
            sync <= {sync[1:0], coil_in};
            done <= term | (done & ~w1c);
            irq  <= done & ctrl[1];
            if (!en || term) begin
                win_gate   <= gate;
                win_base   <= base;
                win_thresh <= thresh;
            end
            if (!en) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
            end else if (term) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                count    <= edge_sum;
                detect   <= dev > win_thresh;
            end else begin
                gate_cnt <= gate_cnt + 1'b1;
                edge_cnt <= edge_sum;
            end
        end
    end

    // Registered read data with a single outstanding read
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_mux;
        end else if (rvalid && s00_axi.rready) begin
            rvalid <= 1'b0;
        end
    end
endmodule
